// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Two-requester round-robin front end for a single UART transmitter.
//   A byte is taken from one requester while IDLE. It is then shifted out
//   LSB first as start / DATA_BITS data / stop, one bit per baud_tick.
//
// Ports
//   clk         system clock
//   rst         synchronous active-low reset
//   baud_tick   one-clk pulse per bit period
//   reqN_valid  requester N has a byte (held until reqN_ready)
//   reqN_data   requester N byte
//   reqN_ready  requester N byte accepted this cycle (combinational)
//   tx          serial line, idle high (registered)
//   busy        frame in progress (registered)
//   grant_id    requester owning the current or last frame (registered)
//   frame_done  one-clk pulse at end of stop bit (registered)

module uart_tx_arbiter #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 req0_valid,
  input  logic [DATA_BITS-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_BITS-1:0] req1_data,
  output logic                 req1_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 grant_id,
  output logic                 frame_done
);

  // Bit counter only needs to reach DATA_BITS-1; keep at least one bit wide.
  localparam int            CW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, SYNC, START, DATA, STOP} state_t;

  state_t                          state, state_nxt;
  logic   [DATA_BITS-1:0]          shreg, shreg_nxt;
  logic   [CW-1:0]                 cnt, cnt_nxt;
  logic                            last_grant, last_grant_nxt;
  logic                            tx_nxt, busy_nxt, grant_id_nxt, frame_done_nxt;

  logic   [1:0]                    vld;
  logic   [1:0][DATA_BITS-1:0]     dat;
  logic   [1:0]                    gnt;
  logic                            xfer;
  logic                            win;

  assign vld = {req1_valid, req0_valid};
  assign dat = {req1_data, req0_data};

  // Round-robin: a lone requester wins; on a tie the one that did not own
  // the previous frame wins. last_grant resets to 1 so requester 0 wins the
  // first tie. Grants are only offered in IDLE and out of reset.
  always_comb begin
    gnt = 2'b00;
    if (rst && state == IDLE) begin
      case (vld)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign xfer       = |gnt;
  assign win        = gnt[1];

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state. The accept cycle never consumes a tick: SYNC always waits
  // for a fresh baud_tick so the start bit is a full bit period.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer)                           state_nxt = SYNC;
      SYNC:    if (baud_tick)                      state_nxt = START;
      START:   if (baud_tick)                      state_nxt = DATA;
      DATA:    if (baud_tick && cnt == LAST_BIT)   state_nxt = STOP;
      STOP:    if (baud_tick)                      state_nxt = IDLE;
      default:                                     state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values. The shift register drops the bit just
  // driven so shreg[0] is always the next data bit to send.
  always_comb begin
    tx_nxt         = tx;
    shreg_nxt      = shreg;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    grant_id_nxt   = grant_id;
    frame_done_nxt = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (xfer) begin
          shreg_nxt      = dat[win];
          grant_id_nxt   = win;
          last_grant_nxt = win;
        end
      end
      SYNC: begin
        if (baud_tick) tx_nxt = 1'b0;
      end
      START: begin
        if (baud_tick) begin
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          cnt_nxt   = '0;
        end
      end
      DATA: begin
        if (baud_tick) begin
          if (cnt == LAST_BIT) begin
            tx_nxt = 1'b1;
          end else begin
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
            cnt_nxt   = cnt + CW'(1);
          end
        end
      end
      STOP: begin
        if (baud_tick) begin
          tx_nxt         = 1'b1;
          frame_done_nxt = 1'b1;
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE);

  // Registered outputs and datapath. Reset aborts any frame in flight and
  // discards its byte.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx         <= 1'b1;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      frame_done <= 1'b0;
      cnt        <= '0;
      last_grant <= 1'b1;
      shreg      <= '0;
    end else begin
      tx         <= tx_nxt;
      busy       <= busy_nxt;
      grant_id   <= grant_id_nxt;
      frame_done <= frame_done_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      shreg      <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed vector table, hand-written multi-cycle
// sequences and a randomized run, all checked every cycle against a
// tick-counting reference model of the frame.
module tb_uart_tx_arbiter;
  localparam int DB          = 8;
  localparam int FRAME_TICKS = DB + 3;  // ticks from accept to end of stop bit

  typedef struct {
    bit          r, t, v0, v1;
    bit [DB-1:0] d0, d1;
    bit          er0, er1, etx, ebusy, egid, efd;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          baud_tick = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [DB-1:0] req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready, tx, busy, grant_id, frame_done;

  int total = 0, bad = 0, gcyc = 0;

  // Reference model: m_k = ticks counted since accept, -1 when idle.
  int          m_k = -1;
  bit          m_last = 1'b1;
  bit [DB-1:0] m_byte = '0;
  bit          m_tx = 1'b1, m_busy = 1'b0, m_gid = 1'b0, m_fd = 1'b0;

  bit [DB-1:0] q0[$], q1[$], acc_d[$];
  bit          acc_g[$], txlog[$];
  int          n_rdy0 = 0, n_rdy1 = 0, n_fd = 0;
  bit          got0, got1;
  bit          exp_a5[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  always #5 clk = ~clk;

  uart_tx_arbiter #(.DATA_BITS(DB)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .tx(tx), .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit tk(int per);
    return (gcyc % per) == per - 1;
  endfunction

  function automatic logic [DB-1:0] accd(int i);
    return (i < acc_d.size()) ? acc_d[i] : 'x;
  endfunction

  function automatic logic accg(int i);
    return (i < acc_g.size()) ? acc_g[i] : 1'bx;
  endfunction

  // One clock: drive, check ready, advance model, clock, check outputs.
  task automatic cyc(bit r, bit t, bit v0, bit [DB-1:0] d0, bit v1, bit [DB-1:0] d1);
    bit e0, e1, bpre;
    rst = r; baud_tick = t;
    req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
    #1;
    e0 = 1'b0; e1 = 1'b0;
    if (r && m_k < 0) begin
      if (v0 && (!v1 || m_last)) e0 = 1'b1;
      else if (v1)               e1 = 1'b1;
    end
    chk("ready0", req0_ready, e0);
    chk("ready1", req1_ready, e1);
    chk("ready_excl", req0_ready & req1_ready, 0);
    chk("ready_busy", (req0_ready | req1_ready) & busy, 0);
    got0 = (req0_ready === 1'b1);
    got1 = (req1_ready === 1'b1);
    if (got0) begin n_rdy0++; acc_d.push_back(d0); acc_g.push_back(1'b0); end
    if (got1) begin n_rdy1++; acc_d.push_back(d1); acc_g.push_back(1'b1); end
    bpre = (busy === 1'b1);

    m_fd = 1'b0;
    if (!r) begin
      m_k = -1; m_tx = 1'b1; m_busy = 1'b0; m_gid = 1'b0; m_last = 1'b1;
    end else if (m_k < 0) begin
      if (e0 || e1) begin
        m_byte = e1 ? d1 : d0; m_gid = e1; m_last = e1; m_k = 0; m_busy = 1'b1;
      end
      m_tx = 1'b1;
    end else if (t) begin
      m_k++;
      if (m_k == FRAME_TICKS) begin
        m_k = -1; m_busy = 1'b0; m_fd = 1'b1; m_tx = 1'b1;
      end else if (m_k == 1)       m_tx = 1'b0;
      else if (m_k <= DB + 1)      m_tx = m_byte[m_k - 2];
      else                         m_tx = 1'b1;
    end

    @(posedge clk); #1;
    gcyc++;
    chk("tx", tx, m_tx);
    chk("busy", busy, m_busy);
    chk("grant_id", grant_id, m_gid);
    chk("frame_done", frame_done, m_fd);
    if (frame_done === 1'b1) n_fd++;
    if (r && t && bpre) txlog.push_back(tx);
  endtask

  // Requesters follow the valid/ready protocol from their queues.
  task automatic step(bit r, bit t);
    bit [DB-1:0] d0, d1;
    d0 = (q0.size() > 0) ? q0[0] : '0;
    d1 = (q1.size() > 0) ? q1[0] : '0;
    cyc(r, t, q0.size() > 0, d0, q1.size() > 0, d1);
    if (got0 && q0.size() > 0) void'(q0.pop_front());
    if (got1 && q1.size() > 0) void'(q1.pop_front());
  endtask

  task automatic run_idle(int per, int budget, string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_k >= 0) && n < budget) begin
      step(1'b1, tk(per));
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  function automatic vec_t mk(bit r, bit t, bit v0, bit [DB-1:0] d0, bit v1, bit [DB-1:0] d1,
                              bit er0, bit er1, bit etx, bit ebusy, bit egid, bit efd);
    vec_t v;
    v.r = r; v.t = t; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
    v.er0 = er0; v.er1 = er1; v.etx = etx; v.ebusy = ebusy; v.egid = egid; v.efd = efd;
    return v;
  endfunction

  initial begin
    vec_t          tv[13];
    int            base_fd, base_r0, base_r1, g;
    logic [DB-1:0] rx;

    //             r  t  v0 d0     v1 d1     r0 r1 tx bsy gid fd
    tv[0]  = mk(0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0);  // reset
    tv[1]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0);  // idle tick ignored
    tv[2]  = mk(1, 1, 1, 8'h81, 0, 8'h00, 1, 0, 1, 1, 0, 0);  // accept + tick collision
    tv[3]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0);  // SYNC holds
    tv[4]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);  // start bit
    tv[5]  = mk(1, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0);  // hold
    tv[6]  = mk(1, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 0);  // bit0 of 0x81
    tv[7]  = mk(1, 1, 0, 8'h00, 1, 8'h34, 0, 0, 0, 1, 0, 0);  // bit1, req1 held off
    tv[8]  = mk(0, 0, 0, 8'h00, 1, 8'h34, 0, 0, 1, 0, 0, 0);  // abort frame
    tv[9]  = mk(1, 0, 1, 8'h12, 1, 8'h34, 1, 0, 1, 1, 0, 0);  // tie -> req0
    tv[10] = mk(0, 1, 0, 8'h00, 1, 8'h34, 0, 0, 1, 0, 0, 0);  // reset again
    tv[11] = mk(1, 0, 0, 8'h00, 1, 8'h34, 0, 1, 1, 1, 1, 0);  // lone req1 wins
    tv[12] = mk(1, 1, 1, 8'h56, 0, 8'h00, 0, 0, 0, 1, 1, 0);  // busy: no ready, start bit

    for (int i = 0; i < 13; i++) begin
      cyc(tv[i].r, tv[i].t, tv[i].v0, tv[i].d0, tv[i].v1, tv[i].d1);
      chk($sformatf("tv%0d_ready0", i), got0, tv[i].er0);
      chk($sformatf("tv%0d_ready1", i), got1, tv[i].er1);
      chk($sformatf("tv%0d_tx", i), tx, tv[i].etx);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].ebusy);
      chk($sformatf("tv%0d_gid", i), grant_id, tv[i].egid);
      chk($sformatf("tv%0d_fd", i), frame_done, tv[i].efd);
    end

    // Single byte 0xA5, tick every 4 clk.
    step(1'b0, 1'b0);
    txlog.delete(); base_fd = n_fd; base_r0 = n_rdy0;
    q0.push_back(8'hA5);
    run_idle(4, 200, "single_timeout");
    repeat (3) step(1'b1, tk(4));
    chk("single_ready_cnt", n_rdy0 - base_r0, 1);
    chk("single_fd_cnt", n_fd - base_fd, 1);
    chk("single_busy_after", busy, 0);
    chk("single_tick_cnt", txlog.size(), FRAME_TICKS);
    for (int i = 0; i < 10; i++)
      chk($sformatf("single_tx%0d", i), (i < txlog.size()) ? txlog[i] : 1'bx, exp_a5[i]);

    // Ties from reset, then a second tie.
    step(1'b0, 1'b0);
    acc_d.delete(); acc_g.delete();
    q0.push_back(8'h11); q1.push_back(8'h22);
    run_idle(2, 300, "tie1_timeout");
    q0.push_back(8'h33); q1.push_back(8'h44);
    run_idle(2, 300, "tie2_timeout");
    chk("tie_d0", accd(0), 8'h11); chk("tie_g0", accg(0), 0);
    chk("tie_d1", accd(1), 8'h22); chk("tie_g1", accg(1), 1);
    chk("tie_d2", accd(2), 8'h33); chk("tie_g2", accg(2), 0);
    chk("tie_d3", accd(3), 8'h44); chk("tie_g3", accg(3), 1);

    // Hold-off: req1 arrives mid-frame of req0.
    step(1'b0, 1'b0);
    acc_d.delete(); acc_g.delete();
    q0.push_back(8'h3C);
    repeat (12) step(1'b1, tk(3));
    q1.push_back(8'h5A); base_r1 = n_rdy1; base_fd = n_fd; g = 0;
    while (n_fd == base_fd && g < 200) begin step(1'b1, tk(3)); g++; end
    chk("hold_frame_timeout", g < 200, 1);
    chk("hold_no_ready1", n_rdy1 - base_r1, 0);
    txlog.delete();
    run_idle(3, 300, "hold_timeout");
    chk("hold_d0", accd(0), 8'h3C);
    chk("hold_d1", accd(1), 8'h5A); chk("hold_g1", accg(1), 1);
    rx = 'x;
    if (txlog.size() >= DB + 1) for (int j = 0; j < DB; j++) rx[j] = txlog[j + 1];
    chk("hold_rx_byte", rx, 8'h5A);

    // Mid-frame reset during data bit 3.
    step(1'b0, 1'b0);
    q0.push_back(8'hC3); base_fd = n_fd; g = 0;
    while (m_k != 5 && g < 100) begin step(1'b1, tk(2)); g++; end
    chk("mr_reach_timeout", g < 100, 1);
    step(1'b0, 1'b0);
    chk("mr_tx", tx, 1); chk("mr_busy", busy, 0); chk("mr_fd", frame_done, 0);
    repeat (30) step(1'b1, tk(2));
    chk("mr_no_fd", n_fd - base_fd, 0);
    acc_d.delete(); acc_g.delete();
    q0.push_back(8'h66); q1.push_back(8'h77);
    run_idle(2, 300, "mr_tie_timeout");
    chk("mr_tie_d0", accd(0), 8'h66); chk("mr_tie_g0", accg(0), 0);

    // Randomized traffic, ticks and occasional resets.
    step(1'b0, 1'b0);
    for (int i = 0; i < 4000; i++) begin
      bit r, t;
      r = ($urandom_range(0, 499) != 0);
      t = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0 && q0.size() < 3) q0.push_back(DB'($urandom));
      if ($urandom_range(0, 9) == 0 && q1.size() < 3) q1.push_back(DB'($urandom));
      step(r, t);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have exactly one clock, clk, and exactly one reset, rst; rst is synchronous and active-low.
REQ-002 Parameter DATA_BITS SHALL default to 8 and set the number of data bits per frame and the width of each requester's data.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- baud_tick  in  1  one-clk pulse per bit period, from the baud generator
- req0_valid  in  1  requester 0 has a byte
- req0_data  in  DATA_BITS  requester 0 byte
- req0_ready  out  1  requester 0 byte accepted this cycle
- req1_valid  in  1  requester 1 has a byte
- req1_data  in  DATA_BITS  requester 1 byte
- req1_ready  out  1  requester 1 byte accepted this cycle
- tx  out  1  serial line, idle high
- busy  out  1  frame in progress
- grant_id  out  1  requester owning the current or last frame
- frame_done  out  1  one-clk pulse at end of stop bit

Function
REQ-004 The FSM SHALL have the states IDLE, SYNC, START, DATA and STOP; busy SHALL be 1 in every state except IDLE.
REQ-005 A transfer SHALL occur on a clk edge where reqN_valid=1 and reqN_ready=1; a requester SHALL hold valid and data stable until ready.
REQ-006 reqN_ready SHALL be combinational, asserted only in IDLE with rst=1, and asserted for at most one requester per cycle.
REQ-007 Arbitration SHALL be round-robin:
- Only one valid: that requester wins.
- Both valid: the requester not equal to last_grant wins.
- last_grant resets to 1, so requester 0 wins the first tie.
REQ-008 On a transfer, the module SHALL:
- load the granted data into an internal shift register;
- set grant_id and last_grant to the winner;
- move to SYNC.
REQ-009 Within a frame, all state and tx changes SHALL occur only on clk edges where baud_tick=1; with baud_tick=0 the state, tx and bit count SHALL hold.
REQ-010 SYNC with baud_tick: tx SHALL go to 0 (start bit) and the state SHALL move to START.
REQ-011 START with baud_tick: tx SHALL take data bit 0, the bit count SHALL be 0, and the state SHALL move to DATA.
REQ-012 DATA with baud_tick, bits SHALL be sent LSB first:
- If the bit count is less than DATA_BITS-1: tx takes the next bit and the count increments.
- If the bit count equals DATA_BITS-1: tx goes to 1 (stop bit) and the state moves to STOP.
- The bit count SHALL be wide enough for DATA_BITS-1 and SHALL NOT wrap.
REQ-013 STOP with baud_tick: frame_done SHALL pulse for exactly one clk, tx SHALL stay 1, and the state SHALL return to IDLE.
REQ-014 In IDLE, baud_tick SHALL be ignored and tx SHALL be 1.
REQ-015 A baud_tick coinciding with a transfer SHALL NOT advance the frame; SYNC SHALL wait for the next baud_tick.
REQ-016 A new transfer SHALL be possible in the first IDLE cycle after STOP; the minimum frame-to-frame gap SHALL be 1 clk plus the wait for a tick in SYNC.
REQ-017 Valid inputs arriving while busy=1 SHALL NOT be accepted, SHALL NOT affect the frame, and SHALL be arbitrated on return to IDLE.
REQ-018 tx, busy, grant_id and frame_done SHALL be registered outputs.

Reset
REQ-019 While rst=0 at a clk edge, the outputs SHALL take these values on the next edge:
- tx=1, busy=0, grant_id=0, frame_done=0
- state=IDLE, bit count=0, last_grant=1, shift register=0
REQ-020 While rst=0, req0_ready and req1_ready SHALL be 0.
REQ-021 Reset asserted mid-frame SHALL abort the frame:
- tx returns to 1 on the next edge;
- no frame_done is produced;
- the aborted byte is discarded.

Verification
REQ-022 Single byte: baud_tick every 4 clk, req0 sends 0xA5 -> req0_ready pulses once; tx sequence per tick is 0,1,0,1,0,0,1,0,1,1; frame_done pulses once; busy=0 afterward.
REQ-023 Tie: req0 and req1 valid together from reset with 0x11 and 0x22 -> 0x11 sent first (grant_id=0), then 0x22 (grant_id=1); a further tie with 0x33 and 0x44 -> 0x33 first.
REQ-024 Hold-off: req1 asserts valid with 0x5A mid-frame of req0 -> req1_ready stays 0 until IDLE, then 0x5A is sent intact.
REQ-025 Tick collision: baud_tick=1 on the transfer cycle -> tx stays 1 that edge; the start bit appears on the following tick.
REQ-026 Mid-frame reset: rst=0 for 1 clk during DATA bit 3 -> next edge has tx=1, busy=0, no frame_done; the next tied request goes to req0.
REQ-027 Ready protocol: across all scenarios, both ready outputs are never 1 in the same cycle, and ready is never 1 while busy=1.
